// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - shared GPIO constants and per-bit debounce state type
package gpio_pkg;

    localparam int GPIO_WIDTH                   = 16;
    localparam int GPIO_DEBOUNCE_CYCLES_DEFAULT = 500000;
    localparam int GPIO_DEBOUNCE_CNT_W          = 20;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } deb_state_e;

endpackage

// File: rtl/gpio_input_debounce_if.sv
// rtl/gpio_input_debounce_if.sv - pad input and debounced output bundle
interface gpio_input_debounce_if import gpio_pkg::*; #(
    parameter int WIDTH = GPIO_WIDTH
);

    logic [WIDTH-1:0] gpio_in;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] rise_pulse;
    logic [WIDTH-1:0] fall_pulse;
    logic             change;

    modport master (
        output gpio_in,
        input  data_out,
        input  rise_pulse,
        input  fall_pulse,
        input  change
    );

    modport slave (
        input  gpio_in,
        output data_out,
        output rise_pulse,
        output fall_pulse,
        output change
    );

endinterface

// File: rtl/gpio_debounce_bit.sv
// rtl/gpio_debounce_bit.sv - single-bit synchronizer, stability counter and edge pulses
module gpio_debounce_bit import gpio_pkg::*; #(
    parameter int CNT_W           = GPIO_DEBOUNCE_CNT_W,
    parameter int DEBOUNCE_CYCLES = GPIO_DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pad,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_event_nxt
);

    // Terminal count: the level is accepted on the edge where the counter
    // already shows DEBOUNCE_CYCLES-1 differing samples.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             r_s1;
    logic             r_s2;
    logic             r_stb;
    logic             r_rise;
    logic             r_fall;
    logic [CNT_W-1:0] r_cnt;
    deb_state_e       r_state;

    deb_state_e       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_stb_nxt;
    logic             w_rise_nxt;
    logic             w_fall_nxt;
    logic             w_differs;

    assign w_differs = r_s2 ^ r_stb;

    // Two-flop synchronizer into clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_pad;
            r_s2 <= r_s1;
        end
    end

    // Next-state: count consecutive differing samples, accept at terminal count,
    // clear on any bounce back to the stable level.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stb_nxt   = r_stb;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_differs) begin
                    if (r_cnt == CNT_LAST) begin
                        w_stb_nxt  = r_s2;
                        w_cnt_nxt  = '0;
                        w_rise_nxt = r_s2;
                        w_fall_nxt = ~r_s2;
                    end else begin
                        w_state_nxt = COUNT;
                        w_cnt_nxt   = r_cnt + CNT_ONE;
                    end
                end
            end
            COUNT: begin
                if (!w_differs) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = IDLE;
                    w_stb_nxt   = r_s2;
                    w_cnt_nxt   = '0;
                    w_rise_nxt  = r_s2;
                    w_fall_nxt  = ~r_s2;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State, stable level and one-cycle pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_stb   <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_stb   <= w_stb_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    assign o_level     = r_stb;
    assign o_rise      = r_rise;
    assign o_fall      = r_fall;
    assign o_event_nxt = w_rise_nxt | w_fall_nxt;

endmodule

// File: rtl/gpio_input_debounce.sv
// rtl/gpio_input_debounce.sv - per-bit GPIO pad debounce with edge and change pulses
module gpio_input_debounce import gpio_pkg::*; #(
    parameter int WIDTH           = GPIO_WIDTH,
    parameter int CNT_W           = GPIO_DEBOUNCE_CNT_W,
    parameter int DEBOUNCE_CYCLES = GPIO_DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    gpio_input_debounce_if.slave bus
);

    logic [WIDTH-1:0] w_level;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_event_nxt;
    logic             r_change;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        gpio_debounce_bit #(
            .CNT_W           (CNT_W),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk         (clk),
            .rst         (rst),
            .i_pad       (bus.gpio_in[g]),
            .o_level     (w_level[g]),
            .o_rise      (w_rise[g]),
            .o_fall      (w_fall[g]),
            .o_event_nxt (w_event_nxt[g])
        );
    end

    // Change flag registered from the same next-pulse terms so it lines up with the pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_change <= 1'b0;
        end else begin
            r_change <= |w_event_nxt;
        end
    end

    assign bus.data_out   = w_level;
    assign bus.rise_pulse = w_rise;
    assign bus.fall_pulse = w_fall;
    assign bus.change     = r_change;

endmodule

// File: tb/tb_gpio_input_debounce.sv
// tb/tb_gpio_input_debounce.sv - self-checking bench for gpio_input_debounce
module tb_gpio_input_debounce;

    localparam int W  = 16;
    localparam int D  = 4;
    localparam int CW = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    gpio_input_debounce_if #(.WIDTH(W)) u_if ();

    gpio_input_debounce #(
        .WIDTH           (W),
        .CNT_W           (CW),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: a level is accepted when the last D synchronized samples
    // all differ from the current stable level. The synchronized sample seen at
    // edge k is the pad sampled at edge k-2; reset forces the two pending samples to 0.
    logic [W-1:0] hist[$];
    logic [W-1:0] m_stb  = '0;
    logic [W-1:0] m_rise = '0;
    logic [W-1:0] m_fall = '0;
    bit           m_valid = 1'b0;

    always @(posedge clk) begin
        bit all_diff;
        int idx;
        m_rise = '0;
        m_fall = '0;
        if (rst) begin
            m_stb = '0;
            if (hist.size() > 0) hist[hist.size()-1] = '0;
            hist.push_back('0);
        end else begin
            for (int i = 0; i < W; i++) begin
                all_diff = 1'b1;
                for (int j = 0; j < D; j++) begin
                    idx = hist.size() - 2 - j;
                    if (idx < 0) all_diff = 1'b0;
                    else if (hist[idx][i] == m_stb[i]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    m_stb[i]  = ~m_stb[i];
                    m_rise[i] = m_stb[i];
                    m_fall[i] = ~m_stb[i];
                end
            end
            hist.push_back(u_if.gpio_in);
        end
        if (hist.size() > 32) void'(hist.pop_front());
        m_valid = 1'b1;
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("data_out",   u_if.data_out,   m_stb);
            chk("rise_pulse", u_if.rise_pulse, m_rise);
            chk("fall_pulse", u_if.fall_pulse, m_fall);
            chk("change",     u_if.change,     |(m_rise | m_fall));
        end
    end

    initial begin
        u_if.gpio_in = '0;
        rst = 1'b1;
        step(3);
        chk("rst_data",   u_if.data_out, 16'h0000);
        chk("rst_change", u_if.change,   1'b0);
        rst = 1'b0;
        step(2);

        // Single bit rise, accepted on the 6th edge.
        u_if.gpio_in = 16'h0001;
        step(5);
        chk("b0_pre_data", u_if.data_out, 16'h0000);
        step(1);
        chk("b0_data",   u_if.data_out,   16'h0001);
        chk("b0_rise",   u_if.rise_pulse, 16'h0001);
        chk("b0_fall",   u_if.fall_pulse, 16'h0000);
        chk("b0_change", u_if.change,     1'b1);
        chk("b0_model",  m_stb,           16'h0001);
        step(1);
        chk("b0_rise_end",   u_if.rise_pulse, 16'h0000);
        chk("b0_change_end", u_if.change,     1'b0);

        // Short glitch on bit 3 is rejected.
        u_if.gpio_in = 16'h0009;
        step(3);
        u_if.gpio_in = 16'h0001;
        step(10);
        chk("glitch_data", u_if.data_out, 16'h0001);

        // Bounce on bit 5, then a steady high.
        for (int k = 0; k < 10; k++) begin
            u_if.gpio_in = u_if.gpio_in ^ 16'h0020;
            step(2);
        end
        u_if.gpio_in = u_if.gpio_in | 16'h0020;
        step(5);
        chk("bounce_pre", u_if.data_out, 16'h0001);
        step(1);
        chk("bounce_data", u_if.data_out,   16'h0021);
        chk("bounce_rise", u_if.rise_pulse, 16'h0020);

        // All bits at once.
        u_if.gpio_in = 16'h0000;
        step(8);
        chk("all_clear", u_if.data_out, 16'h0000);
        u_if.gpio_in = 16'hFFFF;
        step(6);
        chk("all_data",   u_if.data_out,   16'hFFFF);
        chk("all_rise",   u_if.rise_pulse, 16'hFFFF);
        chk("all_fall",   u_if.fall_pulse, 16'h0000);
        chk("all_change", u_if.change,     1'b1);
        chk("all_model",  m_rise,          16'hFFFF);
        step(1);
        chk("all_rise_end", u_if.rise_pulse, 16'h0000);
        u_if.gpio_in = 16'h0000;
        step(6);
        chk("all_fall_pulse", u_if.fall_pulse, 16'hFFFF);
        chk("all_fall_data",  u_if.data_out,   16'h0000);

        // Reset in the middle of a count restarts the full latency.
        step(2);
        u_if.gpio_in = 16'h0080;
        step(3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("midrst_data", u_if.data_out, 16'h0000);
        step(5);
        chk("midrst_pre", u_if.data_out, 16'h0000);
        step(1);
        chk("midrst_data_after", u_if.data_out,   16'h0080);
        chk("midrst_rise",       u_if.rise_pulse, 16'h0080);

        // Randomized pad activity with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < W; b++) begin
                if ($urandom_range(5) == 0) u_if.gpio_in[b] = ~u_if.gpio_in[b];
            end
            rst = ($urandom_range(299) == 0);
            step(1);
        end
        rst = 1'b0;
        step(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_input_debounce.md
# gpio_input_debounce

Front-end conditioning stage for the GPIO input CSR block. Takes raw asynchronous switch/button pad levels, synchronizes each bit into `clk`, and debounces it with a per-bit stability counter. Drives the clean level vector straight into the GPIO input CSR's `DATA_IN` hardware input. Also provides one-cycle rise, fall and change pulses for future interrupt logic.

## Interface

Parameters:
- `WIDTH`, 16: number of GPIO input bits. Matches the `DATA_IN` field width.
- `CNT_W`, 20: debounce counter width.
- `DEBOUNCE_CYCLES`, 500000: cycles a synchronized level must hold before it is accepted (10 ms at 50 MHz). Legal range is 1 to 2^CNT_W.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `gpio_in`  in  WIDTH: raw pad levels, asynchronous to `clk`.
- `data_out`  out  WIDTH: debounced stable levels. Connects to the CSR `DATA_IN` input.
- `rise_pulse`  out  WIDTH: per-bit one-cycle pulse when `data_out[i]` goes 0→1.
- `fall_pulse`  out  WIDTH: per-bit one-cycle pulse when `data_out[i]` goes 1→0.
- `change`  out  1: OR-reduction of `rise_pulse | fall_pulse`, registered in the same cycle as the pulses.

## Operation

- Every bit is fully independent. Bits share no counter or state.
- Synchronizer: two flip-flops, `s1 <= gpio_in[i]`, `s2 <= s1`. Both reset to 0.
- Per-bit state machine, driven by comparing `s2` against the stable level `stb`:
  - IDLE: `s2 == stb`, `cnt == 0`.
    - On `s2 != stb`, go to COUNT and set `cnt <= 1`, or accept immediately when `DEBOUNCE_CYCLES == 1`.
  - COUNT: `s2 != stb`.
    - If `s2 == stb` (bounce back), set `cnt <= 0` and return to IDLE. No output change.
    - Else if `cnt == DEBOUNCE_CYCLES-1`: `stb <= s2`, `cnt <= 0`, fire the matching rise or fall pulse, return to IDLE.
    - Else `cnt <= cnt + 1`.
- Equivalent rule: on every edge where `s2 != stb`, either accept (when `cnt == DEBOUNCE_CYCLES-1`) or increment. On every edge where `s2 == stb`, clear the counter.
- Width and arithmetic: `cnt` is unsigned `CNT_W` bits. It never exceeds `DEBOUNCE_CYCLES-1`, so it never wraps.
- `data_out = stb`, registered.
- Pulses are registered and high for exactly one cycle: the first cycle in which the new `data_out` value is visible. Outside that cycle they are 0.
- A rise and a fall pulse can never coincide on the same bit. Different bits may pulse in the same cycle.

## Timing

- Reset value of every output is 0: `data_out`, `rise_pulse`, `fall_pulse`, `change`. Synchronizers and counters also reset to 0.
- Latency: if a pad changes and then holds steady, `data_out` changes on the (2 + `DEBOUNCE_CYCLES`)th rising edge after the first edge that samples the new level.
- Glitch rejection: any level held for fewer than `DEBOUNCE_CYCLES` cycles at `s2` produces no output change and no pulse.
- Bounce: every return to `s2 == stb` restarts the count. Acceptance happens `DEBOUNCE_CYCLES` cycles after the last transition, and only one pulse is produced.
- Reset mid-count: the whole state clears immediately. After release, a pad still at the new level needs the full 2 + `DEBOUNCE_CYCLES` cycles again.
- Pads held high through reset: `data_out` rises 2 + `DEBOUNCE_CYCLES` cycles after reset release, with a `rise_pulse`. This is required behaviour.
- Simultaneous events on multiple bits are handled in parallel, with no arbitration.
- End-to-end latency: the CSR block adds one register stage, so a software read sees the level one cycle after `data_out` changes.

## Structure

- Shared package `gpio_pkg` holds:
  - `GPIO_WIDTH = 16`
  - `GPIO_DEBOUNCE_CYCLES_DEFAULT = 500000`
  - `GPIO_DEBOUNCE_CNT_W = 20`
  - the per-bit state enum {IDLE, COUNT}
- Sub-module `gpio_debounce_bit`:
  - contains the single-bit synchronizer, counter, FSM and pulse registers;
  - the top level instantiates it `WIDTH` times in a generate loop and ORs the pulses into `change`.

## Test plan

All scenarios use `DEBOUNCE_CYCLES=4`, `WIDTH=16`.

- Reset with `gpio_in=16'h0000` for 3 cycles → `data_out=16'h0000`; `rise_pulse`, `fall_pulse` and `change` all 0 throughout.
- `gpio_in[0]` 0→1, held → `data_out=16'h0001` on the 6th edge after the first sampling edge. `rise_pulse=16'h0001` and `change=1` for exactly that one cycle.
- `gpio_in[3]` high for 3 cycles, then low → `data_out` stays `16'h0000`; no pulse on any output.
- `gpio_in[5]` toggles every 2 cycles for 20 cycles, then holds 1 → exactly one `rise_pulse[5]`, arriving 6 edges after the final transition; `data_out[5]=1`.
- `gpio_in` goes 0→`16'hFFFF` in one cycle → `data_out=16'hFFFF` in a single cycle; `rise_pulse=16'hFFFF`, `fall_pulse=0`, `change=1` for one cycle. Then go to `16'h0000` → `fall_pulse=16'hFFFF` after 6 edges.
- `gpio_in[7]` goes high; assert `rst` after 3 edges for 1 cycle → `data_out[7]=0` with no pulse. After release with the pad still high, `data_out[7]=1` exactly 6 edges later with one `rise_pulse[7]`.
